cmos_gray_bbox: RTL and testbench

- Downstream consumer of the CMOS capture stage's RGB565 pixel stream, in the cam_pclk domain.
- Converts each pixel to 8-bit luma and binarises it against a run-time threshold (dark = 1).
- Tracks the bounding box of dark pixels per frame (eye/pupil candidate region) and publishes it at each frame boundary.
- Forwards an aligned grayscale stream with x/y coordinates for later overlay/storage stages.

---
 rtl/cmos_gray_bbox.sv | 208 ++++++++++++++++++++
 tb/tb_cmos_gray_bbox.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cmos_gray_bbox.sv
// cmos_gray_bbox
// Converts the RGB565 capture stream to 8-bit luma, thresholds it
// (dark = 1) and tracks the bounding box of dark pixels in each frame.
// The box of a completed frame is published at the next frame boundary,
// which is the rising edge of the delayed vsync.
//
// Ports:
//   cam_pclk, rst_n          pixel clock, async active-low reset
//   in_vsync/href/valid      capture-stage sync and pixel strobe
//   in_data[15:0]            RGB565 pixel {R5,G6,B5}
//   thresh[7:0]              dark threshold, taken at each frame boundary
//   out_vsync/href/valid     input sync signals delayed 3 cycles
//   out_gray[7:0], out_bin   luma and dark flag, aligned with out_valid
//   out_x, out_y[10:0]       coordinates of the current output pixel
//   box_xmin/xmax/ymin/ymax  dark bounding box of the last completed frame
//   dark_cnt[19:0]           dark-pixel count of the last completed frame
//   box_valid                dark_cnt >= MIN_DARK
//   box_done                 one-cycle pulse when the box outputs update
module cmos_gray_bbox #(
  parameter int          IMG_W    = 640,
  parameter int          IMG_H    = 480,
  parameter logic [19:0] MIN_DARK = 20'd64
) (
  input  logic        cam_pclk,
  input  logic        rst_n,
  input  logic        in_vsync,
  input  logic        in_href,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  input  logic [7:0]  thresh,
  output logic        out_vsync,
  output logic        out_href,
  output logic        out_valid,
  output logic [7:0]  out_gray,
  output logic        out_bin,
  output logic [10:0] out_x,
  output logic [10:0] out_y,
  output logic [10:0] box_xmin,
  output logic [10:0] box_xmax,
  output logic [10:0] box_ymin,
  output logic [10:0] box_ymax,
  output logic [19:0] dark_cnt,
  output logic        box_valid,
  output logic        box_done
);

  localparam logic [11:0] IMG_W_L = 12'(IMG_W);
  localparam logic [11:0] IMG_H_L = 12'(IMG_H);

  // Luma keeps the integer part of the weighted sum; no rounding.
  function automatic logic [7:0] luma_trunc(input logic [15:0] s);
    return s[15:8];
  endfunction

  function automatic logic [10:0] sat_inc11(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  function automatic logic [19:0] sat_inc20(input logic [19:0] v);
    return (v == 20'hFFFFF) ? v : v + 20'd1;
  endfunction

  // Replicate the top bits so full-scale 5/6-bit codes map to 255.
  logic [7:0] r8, g8, b8;
  assign r8 = {in_data[15:11], in_data[15:13]};
  assign g8 = {in_data[10:5],  in_data[10:9]};
  assign b8 = {in_data[4:0],   in_data[4:2]};

  logic [15:0] prod_r_p0, prod_g_p0, prod_b_p0;
  logic [15:0] sum_p1;
  logic [7:0]  gray_p2;
  logic        bin_p2;
  logic        vld_p0, vld_p1, vld_p2;
  logic        vsync_p0, vsync_p1, vsync_p2;
  logic        href_p0, href_p1, href_p2;
  logic [7:0]  thr_act;

  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      prod_r_p0 <= '0;
      prod_g_p0 <= '0;
      prod_b_p0 <= '0;
      sum_p1    <= '0;
      gray_p2   <= '0;
      bin_p2    <= 1'b0;
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      vsync_p0  <= 1'b0;
      vsync_p1  <= 1'b0;
      vsync_p2  <= 1'b0;
      href_p0   <= 1'b0;
      href_p1   <= 1'b0;
      href_p2   <= 1'b0;
    end else begin
      // S1: weighted products
      prod_r_p0 <= 16'd77  * 16'(r8);
      prod_g_p0 <= 16'd150 * 16'(g8);
      prod_b_p0 <= 16'd29  * 16'(b8);
      vld_p0    <= in_valid;
      vsync_p0  <= in_vsync;
      href_p0   <= in_href;
      // S2: sum, max 65280 so 16 bits never overflow
      sum_p1    <= prod_r_p0 + prod_g_p0 + prod_b_p0;
      vld_p1    <= vld_p0;
      vsync_p1  <= vsync_p0;
      href_p1   <= href_p0;
      // S3: luma and binarisation
      gray_p2   <= luma_trunc(sum_p1);
      bin_p2    <= vld_p1 && (luma_trunc(sum_p1) < thr_act);
      vld_p2    <= vld_p1;
      vsync_p2  <= vsync_p1;
      href_p2   <= href_p1;
    end
  end

  assign out_vsync = vsync_p2;
  assign out_href  = href_p2;
  assign out_valid = vld_p2;
  assign out_gray  = gray_p2;
  assign out_bin   = bin_p2;

  logic        vsync_d, href_d;
  logic        vs_rise, href_fall, in_area, dark_hit;
  logic [10:0] x_cnt, y_cnt;
  logic        frame_seen;
  logic [10:0] trk_xmin, trk_xmax, trk_ymin, trk_ymax;
  logic [19:0] trk_cnt;

  assign vs_rise   = vsync_p2 & ~vsync_d;
  assign href_fall = href_d & ~href_p2;
  assign in_area   = ({1'b0, x_cnt} < IMG_W_L) && ({1'b0, y_cnt} < IMG_H_L);
  assign dark_hit  = vld_p2 & bin_p2 & in_area;
  assign out_x     = x_cnt;
  assign out_y     = y_cnt;

  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d <= 1'b0;
      href_d  <= 1'b0;
      x_cnt   <= '0;
      y_cnt   <= '0;
    end else begin
      vsync_d <= vsync_p2;
      href_d  <= href_p2;
      if (href_fall)   x_cnt <= '0;
      else if (vld_p2) x_cnt <= sat_inc11(x_cnt);
      if (vs_rise)        y_cnt <= '0;
      else if (href_fall) y_cnt <= sat_inc11(y_cnt);
    end
  end

  // Frame boundary has priority over a coincident dark pixel.
  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      frame_seen <= 1'b0;
      thr_act    <= '0;
      trk_xmin   <= '0;
      trk_xmax   <= '0;
      trk_ymin   <= '0;
      trk_ymax   <= '0;
      trk_cnt    <= '0;
      box_xmin   <= '0;
      box_xmax   <= '0;
      box_ymin   <= '0;
      box_ymax   <= '0;
      dark_cnt   <= '0;
      box_valid  <= 1'b0;
      box_done   <= 1'b0;
    end else if (vs_rise) begin
      frame_seen <= 1'b1;
      thr_act    <= thresh;
      box_done   <= frame_seen;
      if (frame_seen) begin
        if (trk_cnt == '0) begin
          box_xmin  <= '0;
          box_xmax  <= '0;
          box_ymin  <= '0;
          box_ymax  <= '0;
          dark_cnt  <= '0;
          box_valid <= 1'b0;
        end else begin
          box_xmin  <= trk_xmin;
          box_xmax  <= trk_xmax;
          box_ymin  <= trk_ymin;
          box_ymax  <= trk_ymax;
          dark_cnt  <= trk_cnt;
          box_valid <= (trk_cnt >= MIN_DARK);
        end
      end
      trk_xmin <= 11'h7FF;
      trk_xmax <= '0;
      trk_ymin <= 11'h7FF;
      trk_ymax <= '0;
      trk_cnt  <= '0;
    end else begin
      box_done <= 1'b0;
      if (dark_hit) begin
        if (x_cnt < trk_xmin) trk_xmin <= x_cnt;
        if (x_cnt > trk_xmax) trk_xmax <= x_cnt;
        if (y_cnt < trk_ymin) trk_ymin <= y_cnt;
        if (y_cnt > trk_ymax) trk_ymax <= y_cnt;
        trk_cnt <= sat_inc20(trk_cnt);
      end
    end
  end

endmodule

// File: tb/tb_cmos_gray_bbox.sv
module tb_cmos_gray_bbox;

  logic        cam_pclk = 1'b0;
  logic        rst_n    = 1'b0;
  logic        in_vsync = 1'b0;
  logic        in_href  = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data  = '0;
  logic [7:0]  thresh   = '0;
  logic        out_vsync, out_href, out_valid, out_bin;
  logic [7:0]  out_gray;
  logic [10:0] out_x, out_y;
  logic [10:0] box_xmin, box_xmax, box_ymin, box_ymax;
  logic [19:0] dark_cnt;
  logic        box_valid, box_done;

  cmos_gray_bbox #(.IMG_W(640), .IMG_H(480), .MIN_DARK(20'd2)) dut (
    .cam_pclk (cam_pclk),
    .rst_n    (rst_n),
    .in_vsync (in_vsync),
    .in_href  (in_href),
    .in_valid (in_valid),
    .in_data  (in_data),
    .thresh   (thresh),
    .out_vsync(out_vsync),
    .out_href (out_href),
    .out_valid(out_valid),
    .out_gray (out_gray),
    .out_bin  (out_bin),
    .out_x    (out_x),
    .out_y    (out_y),
    .box_xmin (box_xmin),
    .box_xmax (box_xmax),
    .box_ymin (box_ymin),
    .box_ymax (box_ymax),
    .dark_cnt (dark_cnt),
    .box_valid(box_valid),
    .box_done (box_done)
  );

  always #5 cam_pclk = ~cam_pclk;

  typedef struct {
    logic [15:0] data;
    logic [7:0]  gray;
  } pix_vec_t;

  pix_vec_t vecs [5];
  int n_chk  = 0;
  int n_pass = 0;
  int pulses;

  task automatic tick();
    @(posedge cam_pclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Lines of 8 pixels; mask bit y*8+x marks a black pixel, others white.
  task automatic send_lines(input logic [31:0] mask, input int nlines);
    for (int y = 0; y < nlines; y++) begin
      for (int x = 0; x < 8; x++) begin
        in_href  = 1'b1;
        in_valid = 1'b1;
        in_data  = mask[y*8+x] ? 16'h0000 : 16'hFFFF;
        tick();
      end
      in_href  = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      tick();
      tick();
    end
    repeat (3) tick();
  endtask

  task automatic do_vsync(output int np);
    np = 0;
    for (int i = 0; i < 10; i++) begin
      in_vsync = (i < 2);
      tick();
      if (box_done === 1'b1) np++;
    end
    in_vsync = 1'b0;
  endtask

  task automatic single_pixel(input logic [15:0] d);
    in_href  = 1'b1;
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_href  = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    tick();
    tick();
  endtask

  initial begin
    vecs[0] = '{16'hFFFF, 8'd255};
    vecs[1] = '{16'hF800, 8'd76};
    vecs[2] = '{16'h07E0, 8'd149};
    vecs[3] = '{16'h001F, 8'd28};
    vecs[4] = '{16'h0000, 8'd0};

    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_box_done", 32'(box_done), 0);
    chk("rst_dark_cnt", 32'(dark_cnt), 0);
    chk("rst_box_xmin", 32'(box_xmin), 0);
    chk("rst_out_x", 32'(out_x), 0);
    rst_n = 1'b1;
    tick();

    // Single-pixel luma with 3-cycle latency
    for (int i = 0; i < 5; i++) begin
      in_href  = 1'b1;
      in_valid = 1'b1;
      in_data  = vecs[i].data;
      tick();
      in_href  = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      tick();
      chk($sformatf("early_valid_%0d", i), 32'(out_valid), 0);
      tick();
      chk($sformatf("valid_%0d", i), 32'(out_valid), 1);
      chk($sformatf("href_%0d", i), 32'(out_href), 1);
      chk($sformatf("gray_%0d", i), 32'(out_gray), 32'(vecs[i].gray));
      tick();
    end

    // First vsync after reset: delayed by 3, no box_done
    thresh   = 8'd100;
    in_vsync = 1'b1;
    tick();
    tick();
    in_vsync = 1'b0;
    chk("vsync_delay_2", 32'(out_vsync), 0);
    tick();
    chk("vsync_delay_3", 32'(out_vsync), 1);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (box_done === 1'b1) pulses++;
    end
    chk("first_vsync_no_done", 32'(pulses), 0);
    chk("y_after_vsync", 32'(out_y), 0);

    // Frame A: dark at (2,1),(5,1),(3,3)
    send_lines(32'h0800_2400, 4);
    chk("A_out_y", 32'(out_y), 4);
    chk("A_out_x", 32'(out_x), 0);
    do_vsync(pulses);
    chk("A_pulses", 32'(pulses), 1);
    chk("A_xmin", 32'(box_xmin), 2);
    chk("A_xmax", 32'(box_xmax), 5);
    chk("A_ymin", 32'(box_ymin), 1);
    chk("A_ymax", 32'(box_ymax), 3);
    chk("A_cnt", 32'(dark_cnt), 3);
    chk("A_valid", 32'(box_valid), 1);

    // Frame B: single dark pixel at (4,2)
    send_lines(32'h0010_0000, 4);
    do_vsync(pulses);
    chk("B_pulses", 32'(pulses), 1);
    chk("B_xmin", 32'(box_xmin), 4);
    chk("B_xmax", 32'(box_xmax), 4);
    chk("B_ymin", 32'(box_ymin), 2);
    chk("B_ymax", 32'(box_ymax), 2);
    chk("B_cnt", 32'(dark_cnt), 1);
    chk("B_valid", 32'(box_valid), 0);

    // Frame C: all white
    send_lines(32'h0, 4);
    do_vsync(pulses);
    chk("C_pulses", 32'(pulses), 1);
    chk("C_xmin", 32'(box_xmin), 0);
    chk("C_ymin", 32'(box_ymin), 0);
    chk("C_xmax", 32'(box_xmax), 0);
    chk("C_ymax", 32'(box_ymax), 0);
    chk("C_cnt", 32'(dark_cnt), 0);
    chk("C_valid", 32'(box_valid), 0);

    // Threshold change only takes effect at the next boundary (gray 65)
    thresh = 8'd10;
    single_pixel(16'h4208);
    chk("thr_old_gray", 32'(out_gray), 65);
    chk("thr_old_bin", 32'(out_bin), 1);
    tick();
    do_vsync(pulses);
    single_pixel(16'h4208);
    chk("thr_new_bin", 32'(out_bin), 0);
    tick();

    // Reset mid-frame with dark pixels already seen
    send_lines(32'h0000_0202, 2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cnt", 32'(dark_cnt), 0);
    chk("mid_rst_xmax", 32'(box_xmax), 0);
    chk("mid_rst_valid", 32'(box_valid), 0);
    chk("mid_rst_out_y", 32'(out_y), 0);
    tick();
    rst_n  = 1'b1;
    thresh = 8'd100;
    tick();
    do_vsync(pulses);
    chk("R_first_no_done", 32'(pulses), 0);
    send_lines(32'h0000_0040, 4);
    do_vsync(pulses);
    chk("R_pulses", 32'(pulses), 1);
    chk("R_xmin", 32'(box_xmin), 6);
    chk("R_xmax", 32'(box_xmax), 6);
    chk("R_ymin", 32'(box_ymin), 0);
    chk("R_ymax", 32'(box_ymax), 0);
    chk("R_cnt", 32'(dark_cnt), 1);
    chk("R_valid", 32'(box_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
